// File: rtl/avalon_to_wishbone_bridge.sv
// avalon_to_wishbone_bridge
// Converts the core's simple request/response memory port into one Wishbone
// classic cycle per request. Handles byte/half/word lane steering on stores,
// lane selection plus sign/zero extension on loads, misaligned-access
// detection and a bus timeout so a dead slave cannot hang the core.
//
// Optional build macro: RESP_REG_EN
//   When defined, wb_ack_i / wb_data_i are registered once before the FSM
//   samples them (pipelined Controller path). Minimum latency becomes 3 cycles.
//   When undefined, ack and read data are sampled directly from the bus.
//
// Handshake (core side): the core raises core_read_i and/or core_write_i with
// address/option/data and holds them until core_response_o pulses for one
// cycle. The request is only sampled in IDLE, so a request still present
// during the response cycle is never taken twice. core_error_o is only
// meaningful in the cycle core_response_o is high. Bus side: wb_cyc_o and
// wb_stb_o rise together and stay high with constant we/sel/addr/data until
// an ack is seen or the timeout expires.
module avalon_to_wishbone_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  core_read_i,
    input  logic                  core_write_i,
    input  logic [2:0]            core_option_i,
    input  logic [ADDR_WIDTH-1:0] core_address_i,
    input  logic [DATA_WIDTH-1:0] core_write_data_i,
    output logic [DATA_WIDTH-1:0] core_read_data_o,
    output logic                  core_response_o,
    output logic                  core_error_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  wb_ack_i
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Access size encoding derived from the option field
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Timeout counter just wide enough to reach TIMEOUT_CYCLES
    localparam int              CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT_CYCLES);

    // Registered state
    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [2:0]            opt_q, opt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            sel_q, sel_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cyc_q, cyc_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  resp_q, resp_d;
    logic                  err_q, err_d;

    // Request-side decode
    logic [1:0]            req_size;
    logic                  req_misaligned;
    logic [3:0]            req_sel;
    logic [DATA_WIDTH-1:0] req_wdata;

    // Load-side decode
    logic [1:0]            ld_size;
    logic [DATA_WIDTH-1:0] ld_lane;
    logic [DATA_WIDTH-1:0] ld_result;

    // Bus response as seen by the FSM
    logic                  bus_ack;
    logic [DATA_WIDTH-1:0] bus_dat;

    logic [CNT_W-1:0]      cnt_inc;

`ifdef RESP_REG_EN
    logic                  ack_r_q;
    logic [DATA_WIDTH-1:0] dat_r_q;

    // Register the bus response; an ack while no cycle is open is dropped here
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            ack_r_q <= 1'b0;
            dat_r_q <= '0;
        end else begin
            ack_r_q <= wb_ack_i & cyc_q;
            dat_r_q <= wb_data_i;
        end
    end

    assign bus_ack = ack_r_q;
    assign bus_dat = dat_r_q;
`else
    assign bus_ack = wb_ack_i;
    assign bus_dat = wb_data_i;
`endif

    // Decode size, alignment, byte selects and replicated store data of the incoming request
    always_comb begin
        case (core_option_i)
            3'b000, 3'b100: req_size = SZ_BYTE;
            3'b001, 3'b101: req_size = SZ_HALF;
            default:        req_size = SZ_WORD;
        endcase

        req_misaligned = 1'b0;
        req_sel        = 4'b1111;
        req_wdata      = core_write_data_i;
        case (req_size)
            SZ_BYTE: begin
                req_sel   = 4'b0001 << core_address_i[1:0];
                req_wdata = {4{core_write_data_i[7:0]}};
            end
            SZ_HALF: begin
                req_misaligned = core_address_i[0];
                req_sel        = 4'b0011 << core_address_i[1:0];
                req_wdata      = {2{core_write_data_i[15:0]}};
            end
            default: begin
                req_misaligned = |core_address_i[1:0];
                req_sel        = 4'b1111;
                req_wdata      = core_write_data_i;
            end
        endcase
    end

    // Pick the addressed lane out of the bus word and extend it to 32 bits
    always_comb begin
        case (opt_q)
            3'b000, 3'b100: ld_size = SZ_BYTE;
            3'b001, 3'b101: ld_size = SZ_HALF;
            default:        ld_size = SZ_WORD;
        endcase

        ld_lane = bus_dat >> {addr_q[1:0], 3'b000};
        case (ld_size)
            SZ_BYTE: ld_result = {{24{ld_lane[7] & ~opt_q[2]}}, ld_lane[7:0]};
            SZ_HALF: ld_result = {{16{ld_lane[15] & ~opt_q[2]}}, ld_lane[15:0]};
            default: ld_result = bus_dat;
        endcase
    end

    // Next-state logic: accept in IDLE, wait for ack or timeout in BUS, pulse in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        opt_d   = opt_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        cyc_d   = cyc_q;
        rdata_d = rdata_q;
        resp_d  = 1'b0;
        err_d   = 1'b0;
        cnt_inc = cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (core_read_i || core_write_i) begin
                    // Write wins when both strobes are raised
                    we_d    = core_write_i;
                    opt_d   = core_option_i;
                    addr_d  = core_address_i;
                    sel_d   = req_sel;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    if (req_misaligned) begin
                        // Reject without touching the bus
                        state_d = ST_RESP;
                        resp_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_BUS;
                        cyc_d   = 1'b1;
                    end
                end
            end

            ST_BUS: begin
                if (bus_ack) begin
                    state_d = ST_RESP;
                    cyc_d   = 1'b0;
                    resp_d  = 1'b1;
                    rdata_d = we_q ? '0 : ld_result;
                end else if (TIMEOUT_EN && (cnt_inc == TO_LIMIT)) begin
                    // This was the last permitted BUS cycle without an ack
                    state_d = ST_RESP;
                    cyc_d   = 1'b0;
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            opt_q   <= 3'b000;
            addr_q  <= '0;
            sel_q   <= 4'b0000;
            wdata_q <= '0;
            cyc_q   <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            opt_q   <= opt_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            cyc_q   <= cyc_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    assign core_read_data_o = rdata_q;
    assign core_response_o  = resp_q;
    assign core_error_o     = err_q;
    assign wb_cyc_o         = cyc_q;
    assign wb_stb_o         = cyc_q;
    assign wb_we_o          = we_q;
    assign wb_sel_o         = sel_q;
    assign wb_addr_o        = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign wb_data_o        = wdata_q;

endmodule

// File: tb/tb_avalon_to_wishbone_bridge.sv
// Testbench for avalon_to_wishbone_bridge (TIMEOUT_CYCLES = 4).
module tb_avalon_to_wishbone_bridge;
  localparam int TO = 4;
`ifdef RESP_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_read_i = 1'b0;
  logic        core_write_i = 1'b0;
  logic [2:0]  core_option_i = 3'b000;
  logic [31:0] core_address_i = 32'h0;
  logic [31:0] core_write_data_i = 32'h0;
  logic [31:0] core_read_data_o;
  logic        core_response_o;
  logic        core_error_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i = 32'h0;
  logic        wb_ack_i = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  avalon_to_wishbone_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .core_read_i(core_read_i), .core_write_i(core_write_i), .core_option_i(core_option_i),
    .core_address_i(core_address_i), .core_write_data_i(core_write_data_i),
    .core_read_data_o(core_read_data_o), .core_response_o(core_response_o), .core_error_o(core_error_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] opt);
    if (opt == 3'b000 || opt == 3'b100) return 1;
    if (opt == 3'b001 || opt == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit is_misaligned(input logic [2:0] opt, input logic [31:0] addr);
    return (addr % size_of(opt)) != 0;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [2:0] opt, input logic [31:0] addr);
    int sz;
    sz = size_of(opt);
    if (sz == 1) return 4'(32'd1 << (addr % 32'd4));
    if (sz == 2) return 4'(32'd3 << (addr % 32'd4));
    return 4'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] opt, input logic [31:0] wd);
    int sz;
    sz = size_of(opt);
    if (sz == 1) return (wd % 32'd256) * 32'h0101_0101;
    if (sz == 2) return (wd % 32'd65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] opt, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] lane;
    logic [31:0] v;
    int sz;
    sz = size_of(opt);
    if (sz == 4) return data;
    lane = data >> (32'd8 * (addr % 32'd4));
    v = (sz == 1) ? lane % 32'd256 : lane % 32'd65536;
    if (opt[2] == 1'b0 && sz == 1 && v >= 32'd128) v = v - 32'd256;
    if (opt[2] == 1'b0 && sz == 2 && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Issues one core request, plays the slave (ack in the ack_at-th cyc cycle,
  // 0 = never) and records what the bus and core ports showed.
  task automatic run_txn(
    input logic rd, input logic wr, input logic [2:0] opt, input logic [31:0] addr,
    input logic [31:0] wd, input int ack_at, input logic [31:0] bus_rd,
    output int cyc_n, output int resp_at, output int resp_n, output logic err,
    output logic [31:0] rdata, output logic [3:0] sel, output logic [31:0] baddr,
    output logic [31:0] bdata, output logic we, output logic stable);
    core_read_i = rd; core_write_i = wr; core_option_i = opt;
    core_address_i = addr; core_write_data_i = wd;
    cyc_n = 0; resp_at = -1; resp_n = 0; err = 1'b0; rdata = '0;
    sel = '0; baddr = '0; bdata = '0; we = 1'b0; stable = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      wb_ack_i = 1'b0;
      wb_data_i = $urandom;
      if (wb_stb_o !== wb_cyc_o) stable = 1'b0;
      if (wb_cyc_o) begin
        cyc_n++;
        if (cyc_n == 1) begin
          sel = wb_sel_o; baddr = wb_addr_o; bdata = wb_data_o; we = wb_we_o;
        end else if (wb_sel_o !== sel || wb_addr_o !== baddr || wb_data_o !== bdata || wb_we_o !== we) begin
          stable = 1'b0;
        end
        if (cyc_n == ack_at) begin
          wb_ack_i = 1'b1;
          wb_data_i = bus_rd;
        end
      end
      if (core_response_o) begin
        resp_n++;
        if (resp_at < 0) begin
          resp_at = c; err = core_error_o; rdata = core_read_data_o;
        end
        core_read_i = 1'b0; core_write_i = 1'b0;
      end
      if (resp_at > 0 && c >= resp_at + 2) break;
    end
    core_read_i = 1'b0; core_write_i = 1'b0; wb_ack_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({core_read_data_o, core_response_o, core_error_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o} !== '0)
      begin failures++; $display("FAIL reset_outputs: rdata=%h resp=%b err=%b cyc=%b stb=%b we=%b sel=%b addr=%h data=%h, required all zero",
        core_read_data_o, core_response_o, core_error_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o); end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({core_response_o, wb_cyc_o} !== 2'b00)
      begin failures++; $display("FAIL reset_idle: resp=%b cyc=%b, required 0 0", core_response_o, wb_cyc_o); end
  endtask

  task automatic test_lw();
    int cyc_n, resp_at, resp_n; logic err, we, stable; logic [31:0] rdata, baddr, bdata; logic [3:0] sel;
    run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hCAFE_BABE, cyc_n, resp_at, resp_n, err, rdata, sel, baddr, bdata, we, stable);
    checks++; if (sel !== 4'b1111) begin failures++; $display("FAIL lw_sel: got %b required 1111", sel); end
    checks++; if (baddr !== 32'h100) begin failures++; $display("FAIL lw_addr: got %h required 00000100", baddr); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL lw_we: got %b required 0", we); end
    checks++; if (cyc_n !== 3 + EXTRA) begin failures++; $display("FAIL lw_cyc_len: got %0d required %0d", cyc_n, 3 + EXTRA); end
    checks++; if (resp_at !== 4 + EXTRA) begin failures++; $display("FAIL lw_latency: got %0d required %0d", resp_at, 4 + EXTRA); end
    checks++; if (rdata !== 32'hCAFE_BABE) begin failures++; $display("FAIL lw_rdata: got %h required cafebabe", rdata); end
    checks++; if (err !== 1'b0 || resp_n !== 1) begin failures++; $display("FAIL lw_resp: err=%b pulses=%0d required 0 and 1", err, resp_n); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL lw_stable: got %b required 1", stable); end
  endtask

  task automatic test_sb();
    int cyc_n, resp_at, resp_n; logic err, we, stable; logic [31:0] rdata, baddr, bdata; logic [3:0] sel;
    run_txn(1'b0, 1'b1, 3'b000, 32'h203, 32'h0000_00A5, 1, 32'hFFFF_FFFF, cyc_n, resp_at, resp_n, err, rdata, sel, baddr, bdata, we, stable);
    checks++; if (sel !== 4'b1000) begin failures++; $display("FAIL sb_sel: got %b required 1000", sel); end
    checks++; if (bdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sb_wdata: got %h required a5a5a5a5", bdata); end
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL sb_we: got %b required 1", we); end
    checks++; if (baddr !== 32'h200) begin failures++; $display("FAIL sb_addr: got %h required 00000200", baddr); end
    checks++; if (err !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL sb_resp: err=%b rdata=%h required 0 00000000", err, rdata); end
    checks++; if (resp_at !== 2 + EXTRA) begin failures++; $display("FAIL sb_latency: got %0d required %0d", resp_at, 2 + EXTRA); end
  endtask

  task automatic test_lh_lhu();
    int cyc_n, resp_at, resp_n; logic err, we, stable; logic [31:0] rdata, baddr, bdata; logic [3:0] sel;
    run_txn(1'b1, 1'b0, 3'b001, 32'h302, 32'h0, 2, 32'h8001_5A3C, cyc_n, resp_at, resp_n, err, rdata, sel, baddr, bdata, we, stable);
    checks++; if (rdata !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_rdata: got %h required ffff8001", rdata); end
    checks++; if (sel !== 4'b1100) begin failures++; $display("FAIL lh_sel: got %b required 1100", sel); end
    run_txn(1'b1, 1'b0, 3'b101, 32'h302, 32'h0, 1, 32'h8001_C3C3, cyc_n, resp_at, resp_n, err, rdata, sel, baddr, bdata, we, stable);
    checks++; if (rdata !== 32'h0000_8001) begin failures++; $display("FAIL lhu_rdata: got %h required 00008001", rdata); end
    checks++; if (sel !== 4'b1100 || err !== 1'b0) begin failures++; $display("FAIL lhu_sel: sel=%b err=%b required 1100 0", sel, err); end
  endtask

  task automatic test_misaligned();
    int cyc_n, resp_at, resp_n; logic err, we, stable; logic [31:0] rdata, baddr, bdata; logic [3:0] sel;
    run_txn(1'b1, 1'b0, 3'b010, 32'h401, 32'h0, 1, 32'h1111_1111, cyc_n, resp_at, resp_n, err, rdata, sel, baddr, bdata, we, stable);
    checks++; if (cyc_n !== 0) begin failures++; $display("FAIL mis_lw_nocyc: cyc cycles %0d required 0", cyc_n); end
    checks++; if (resp_at !== 1 || err !== 1'b1) begin failures++; $display("FAIL mis_lw_resp: at=%0d err=%b required 1 1", resp_at, err); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mis_lw_rdata: got %h required 00000000", rdata); end
    run_txn(1'b0, 1'b1, 3'b001, 32'h301, 32'hBEEF, 1, 32'h0, cyc_n, resp_at, resp_n, err, rdata, sel, baddr, bdata, we, stable);
    checks++; if (cyc_n !== 0 || err !== 1'b1 || resp_n !== 1) begin failures++; $display("FAIL mis_sh: cyc=%0d err=%b pulses=%0d required 0 1 1", cyc_n, err, resp_n); end
  endtask

  task automatic test_timeout();
    int cyc_n, resp_at, resp_n, seen; logic err, we, stable; logic [31:0] rdata, baddr, bdata; logic [3:0] sel;
    run_txn(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 0, 32'h0, cyc_n, resp_at, resp_n, err, rdata, sel, baddr, bdata, we, stable);
    checks++; if (cyc_n !== TO) begin failures++; $display("FAIL to_cyc_len: got %0d required %0d", cyc_n, TO); end
    checks++; if (resp_at !== TO + 1 || err !== 1'b1) begin failures++; $display("FAIL to_resp: at=%0d err=%b required %0d 1", resp_at, err, TO + 1); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL to_rdata: got %h required 00000000", rdata); end
    // late ack from the slave while idle
    wb_ack_i = 1'b1; wb_data_i = 32'hDEAD_BEEF;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 1) wb_ack_i = 1'b0;
      if (core_response_o || wb_cyc_o) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL to_late_ack: activity cycles %0d required 0", seen); end
    run_txn(1'b1, 1'b0, 3'b100, 32'h601, 32'h0, 2, 32'h0000_F700, cyc_n, resp_at, resp_n, err, rdata, sel, baddr, bdata, we, stable);
    checks++; if (rdata !== 32'h0000_00F7 || err !== 1'b0) begin failures++; $display("FAIL to_next_req: rdata=%h err=%b required 000000f7 0", rdata, err); end
  endtask

  task automatic test_reset_mid_bus();
    int cyc_n, resp_at, resp_n, seen_cyc, seen_resp; logic err, we, stable; logic [31:0] rdata, baddr, bdata; logic [3:0] sel;
    core_read_i = 1'b1; core_option_i = 3'b010; core_address_i = 32'h500;
    seen_cyc = 0;
    for (int c = 0; c < 10 && seen_cyc < 2; c++) begin
      tick();
      if (wb_cyc_o) seen_cyc++;
    end
    checks++; if (seen_cyc !== 2) begin failures++; $display("FAIL rst_bus_start: cyc cycles %0d required 2", seen_cyc); end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({wb_cyc_o, wb_stb_o, core_response_o, core_error_o} !== 4'b0000 || core_read_data_o !== 32'h0)
      begin failures++; $display("FAIL rst_mid_bus: cyc=%b stb=%b resp=%b err=%b rdata=%h required all zero",
        wb_cyc_o, wb_stb_o, core_response_o, core_error_o, core_read_data_o); end
    rst_n = 1'b1; core_read_i = 1'b0;
    wb_ack_i = 1'b1; wb_data_i = 32'h1234_5678;
    seen_cyc = 0; seen_resp = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      wb_ack_i = 1'b0;
      if (core_response_o) seen_resp++;
      if (wb_cyc_o) seen_cyc++;
    end
    checks++; if (seen_resp !== 0 || seen_cyc !== 0) begin failures++; $display("FAIL rst_stale_ack: resp=%0d cyc=%0d required 0 0", seen_resp, seen_cyc); end
    run_txn(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 2, 32'h0BAD_F00D, cyc_n, resp_at, resp_n, err, rdata, sel, baddr, bdata, we, stable);
    checks++; if (rdata !== 32'h0BAD_F00D || err !== 1'b0 || resp_at !== 3 + EXTRA)
      begin failures++; $display("FAIL rst_after_lw: rdata=%h err=%b at=%0d required 0badf00d 0 %0d", rdata, err, resp_at, 3 + EXTRA); end
  endtask

  task automatic test_random();
    logic [2:0] opt_tab [0:7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    int cyc_n, resp_at, resp_n, ack_at, sz; logic err, we, stable; logic [31:0] rdata, baddr, bdata; logic [3:0] sel;
    logic rd, wr, mis, exp_we; logic [2:0] opt; logic [31:0] addr, wd, bus_rd, exp_rd;
    for (int n = 0; n < 60; n++) begin
      opt = opt_tab[$urandom_range(0, 7)];
      sz = size_of(opt);
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr = addr - (addr % sz);
      wd = $urandom; bus_rd = $urandom;
      case ($urandom_range(0, 2))
        0: begin rd = 1'b1; wr = 1'b0; end
        1: begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      ack_at = $urandom_range(1, 3);
      mis = is_misaligned(opt, addr);
      exp_we = wr;
      exp_q.push_back((mis || exp_we) ? 32'h0 : exp_load(opt, addr, bus_rd));
      run_txn(rd, wr, opt, addr, wd, ack_at, bus_rd, cyc_n, resp_at, resp_n, err, rdata, sel, baddr, bdata, we, stable);
      exp_rd = exp_q.pop_front();
      checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL rnd_rdata[%0d]: opt=%b addr=%h got %h required %h", n, opt, addr, rdata, exp_rd); end
      checks++; if (err !== mis || resp_n !== 1) begin failures++; $display("FAIL rnd_err[%0d]: err=%b pulses=%0d required %b 1", n, err, resp_n, mis); end
      if (mis) begin
        checks++; if (cyc_n !== 0 || resp_at !== 1) begin failures++; $display("FAIL rnd_mis[%0d]: cyc=%0d at=%0d required 0 1", n, cyc_n, resp_at); end
      end else begin
        checks++; if (resp_at !== ack_at + EXTRA + 1 || cyc_n !== ack_at + EXTRA)
          begin failures++; $display("FAIL rnd_timing[%0d]: at=%0d cyc=%0d required %0d %0d", n, resp_at, cyc_n, ack_at + EXTRA + 1, ack_at + EXTRA); end
        checks++; if (sel !== exp_sel(opt, addr) || baddr !== addr - (addr % 32'd4) || we !== exp_we || stable !== 1'b1)
          begin failures++; $display("FAIL rnd_bus[%0d]: sel=%b addr=%h we=%b stable=%b required %b %h %b 1", n, sel, baddr, we, stable, exp_sel(opt, addr), addr - (addr % 32'd4), exp_we); end
        if (exp_we) begin
          checks++; if (bdata !== exp_wdata(opt, wd)) begin failures++; $display("FAIL rnd_wdata[%0d]: opt=%b got %h required %h", n, opt, bdata, exp_wdata(opt, wd)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb();
    test_lh_lhu();
    test_misaligned();
    test_timeout();
    test_reset_mid_bus();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
